// File: rtl/pcg_noise_gen.sv
// pcg_noise_gen: PCG-style pixel noise generator (LCG state + xorshift/rotate output permutation)
//   clk         - sole clock, rising edge
//   reset       - synchronous active-high reset
//   pix_en      - pixel strobe; state, hold counter and noise freeze while low
//   frame_start - one-cycle pulse at frame start; restarts the hold counter
//   seed_load   - loads seed into the state (highest priority)
//   seed        - seed value
//   mask        - per-bit noise enable, sampled when a new sample is taken
//   noise       - registered masked noise
//   noise_valid - one-cycle pulse when noise takes a new sample
// Optional feature: define PCG_NOISE_FRAME_RESEED_EN to reload the latched seed at every
// frame_start so each frame repeats identical noise; otherwise the noise animates.
module pcg_noise_gen #(
   parameter int                 STATE_W = 16,
   parameter int                 OUT_W   = 8,
   parameter logic [STATE_W-1:0] MULT    = STATE_W'(16'h5851),
   parameter logic [STATE_W-1:0] INC     = STATE_W'(16'h1405),
   parameter int                 HOLD    = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_en,
   input  logic               frame_start,
   input  logic               seed_load,
   input  logic [STATE_W-1:0] seed,
   input  logic [OUT_W-1:0]   mask,
   output logic [OUT_W-1:0]   noise,
   output logic               noise_valid
);
   localparam int RB = $clog2(OUT_W);
   localparam int HALF = STATE_W / 2;
   localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

   logic [STATE_W-1:0] state_q, state_d, lcg;
   logic [3:0]         hold_q, hold_d;
   logic [OUT_W-1:0]   noise_q, noise_d;
   logic               valid_q, adv;

   // Xorshift the high half down, take the OUT_W bits just below the rotate field,
   // then rotate right by the top RB state bits.
   function automatic logic [OUT_W-1:0] perm_f(input logic [STATE_W-1:0] s);
      logic [OUT_W-1:0] x;
      logic [RB-1:0]    r;
      x = OUT_W'((s ^ (s >> HALF)) >> (STATE_W - RB - OUT_W));
      r = s[STATE_W-1 -: RB];
      return OUT_W'({x, x} >> r);
   endfunction

`ifdef PCG_NOISE_FRAME_RESEED_EN
   logic [STATE_W-1:0] seed_reg_q, seed_reg_d;
   always_comb seed_reg_d = seed_load ? seed : seed_reg_q;
   always_ff @(posedge clk) seed_reg_q <= reset ? '0 : seed_reg_d;
`endif

   always_comb begin
      lcg = STATE_W'(state_q * MULT + INC);
      // seed_load and frame_start both pre-empt an advance in the same cycle
      adv = pix_en && hold_q == HOLD_LAST && !seed_load && !frame_start;
`ifdef PCG_NOISE_FRAME_RESEED_EN
      state_d = seed_load ? seed : frame_start ? seed_reg_q : adv ? lcg : state_q;
`else
      state_d = seed_load ? seed : adv ? lcg : state_q;
`endif
      hold_d = (seed_load || frame_start) ? 4'd0 :
               !pix_en                    ? hold_q :
               hold_q == HOLD_LAST        ? 4'd0 : 4'(hold_q + 4'd1);
      noise_d = adv ? perm_f(lcg) & mask : noise_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= '0;
         hold_q  <= '0;
         noise_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         noise_q <= noise_d;
         valid_q <= adv;
      end
   end

   assign noise = noise_q;
   assign noise_valid = valid_q;
endmodule

// File: tb/tb_pcg_noise_gen.sv
// tb_pcg_noise_gen: randomized and directed check of pcg_noise_gen (HOLD=1 and HOLD=4) against a reference model
module tb_pcg_noise_gen;
   logic        clk = 1'b0;
   logic        reset = 1'b1, pix_en = 1'b0, frame_start = 1'b0, seed_load = 1'b0;
   logic [15:0] seed = '0;
   logic [7:0]  mask = 8'hFF;
   logic [7:0]  noise1, noise4;
   logic        nv1, nv4;
   int          n_chk = 0, n_fail = 0;
   int unsigned ms[2], mr[2], mh[2];
   logic [7:0]  mn[2];
   logic        mv[2];
   int          hl[2] = '{1, 4};

   always #5 clk = ~clk;

   pcg_noise_gen u1 (.clk(clk), .reset(reset), .pix_en(pix_en), .frame_start(frame_start),
      .seed_load(seed_load), .seed(seed), .mask(mask), .noise(noise1), .noise_valid(nv1));
   pcg_noise_gen #(.HOLD(4)) u4 (.clk(clk), .reset(reset), .pix_en(pix_en), .frame_start(frame_start),
      .seed_load(seed_load), .seed(seed), .mask(mask), .noise(noise4), .noise_valid(nv4));

   function automatic logic [7:0] pmod(int unsigned s);
      int unsigned x, r;
      x = ((s ^ (s >> 8)) >> 5) & 255;
      r = s >> 13;
      return 8'(((x >> r) | (x << (8 - r))) & 255);
   endfunction

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic p, input logic f, input logic l,
                       input logic [15:0] sd, input logic [7:0] mk);
      reset = r; pix_en = p; frame_start = f; seed_load = l; seed = sd; mask = mk;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         mv[i] = 1'b0;
         if (r) begin
            ms[i] = 0; mr[i] = 0; mh[i] = 0; mn[i] = 8'h00;
         end else if (l) begin
            ms[i] = sd; mr[i] = sd; mh[i] = 0;
         end else if (f) begin
            mh[i] = 0;
`ifdef PCG_NOISE_FRAME_RESEED_EN
            ms[i] = mr[i];
`endif
         end else if (p) begin
            mh[i] = (mh[i] + 1) % hl[i];
            if (mh[i] == 0) begin
               ms[i] = (ms[i] * 32'h5851 + 32'h1405) & 32'hFFFF;
               mn[i] = pmod(ms[i]) & mk;
               mv[i] = 1'b1;
            end
         end
      end
      chk("noise_h1", noise1, mn[0]);
      chk("valid_h1", {7'd0, nv1}, {7'd0, mv[0]});
      chk("noise_h4", noise4, mn[1]);
      chk("valid_h4", {7'd0, nv4}, {7'd0, mv[1]});
   endtask

   initial begin
      int pulses;
      logic [7:0] seq_a[3];
      step(1, 0, 0, 0, 16'h0, 8'hFF);
      step(1, 1, 0, 0, 16'h0, 8'hFF);
      chk("reset_noise", noise1, 8'h00);
      // first two samples from reset with HOLD=1
      step(0, 1, 0, 0, 16'h0, 8'hFF);
      chk("first_a0", noise1, 8'hA0);
      chk("first_valid", {7'd0, nv1}, 8'h01);
      step(0, 1, 0, 0, 16'h0, 8'hFF);
      chk("second_86", noise1, 8'h86);
      // HOLD=4 duty cycle over 8 pix cycles
      step(1, 0, 0, 0, 16'h0, 8'hFF);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 0, 0, 16'h0, 8'hFF);
         pulses += int'(nv4);
      end
      chk("hold4_pulses", 8'(pulses), 8'd2);
      // pix_en 1,0,1 : noise stable in the idle cycle
      step(1, 0, 0, 0, 16'h0, 8'hFF);
      step(0, 1, 0, 0, 16'h0, 8'hFF);
      step(0, 0, 0, 0, 16'h0, 8'hFF);
      chk("idle_hold", noise1, 8'hA0);
      chk("idle_valid", {7'd0, nv1}, 8'h00);
      step(0, 1, 0, 0, 16'h0, 8'hFF);
      chk("resume_86", noise1, 8'h86);
      // mask on first sample
      step(1, 0, 0, 0, 16'h0, 8'h0F);
      step(0, 1, 0, 0, 16'h0, 8'h0F);
      chk("mask_0f", noise1, 8'h00);
      // seed_load beats frame_start, then advance from seed 0
      step(0, 1, 0, 0, 16'h0, 8'hFF);
      step(0, 1, 1, 1, 16'h0000, 8'hFF);
      chk("seed_no_valid", {7'd0, nv1}, 8'h00);
      step(0, 1, 0, 0, 16'h0, 8'hFF);
      chk("seed_then_a0", noise1, 8'hA0);
      // frame reseed behaviour: 3 samples, frame_start, 3 samples
      step(0, 0, 0, 1, 16'h0000, 8'hFF);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0, 16'h0, 8'hFF);
         seq_a[i] = noise1;
      end
      step(0, 1, 1, 0, 16'h0, 8'hFF);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0, 16'h0, 8'hFF);
`ifdef PCG_NOISE_FRAME_RESEED_EN
         chk("reseed_repeat", noise1, seq_a[i]);
`else
         chk("animate_differs", {7'd0, noise1 != seq_a[i]}, 8'h01);
`endif
      end
      // randomized traffic including collisions with reset
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(99) < 2, $urandom_range(99) < 70, $urandom_range(99) < 5,
              $urandom_range(99) < 4, 16'($urandom), 8'($urandom));
      end
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule

// File: doc/pcg_noise_gen.md
PCG_NOISE_GEN -- requirements
Module: pcg_noise_gen

Interface
REQ-001 The block SHALL have parameter STATE_W, default 16, LCG state width (16 or 32).
REQ-002 The block SHALL have parameter OUT_W, default 8, noise output width (power of two, 4..STATE_W/2).
REQ-003 The block SHALL have parameter MULT, default 16'h5851 zero-extended to STATE_W, LCG multiplier.
REQ-004 The block SHALL have parameter INC, default 16'h1405 zero-extended to STATE_W, LCG increment (odd).
REQ-005 The block SHALL have parameter HOLD, default 1, pixels per noise sample (1..16).
REQ-006 The block SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have port pix_en, input, 1, pixel strobe, typically display_on.
REQ-009 The block SHALL have port frame_start, input, 1, one-cycle pulse at the start of each frame.
REQ-010 The block SHALL have port seed_load, input, 1, loads seed into the state.
REQ-011 The block SHALL have port seed, input, STATE_W, seed value.
REQ-012 The block SHALL have port mask, input, OUT_W, per-bit noise enable.
REQ-013 The block SHALL have port noise, output, OUT_W, registered masked noise.
REQ-014 The block SHALL have port noise_valid, output, 1, one-cycle pulse when noise takes a new sample.

Function
REQ-015 The state SHALL update as state <= state*MULT + INC mod 2^STATE_W on an advance cycle.
REQ-016 An advance cycle SHALL be pix_en=1 with hold_cnt==HOLD-1; on each pix_en=1 cycle hold_cnt SHALL increment and wrap to 0 after HOLD-1.
REQ-017 With pix_en=0, state and hold_cnt SHALL freeze, and noise SHALL hold its value.
REQ-018 RB=log2(OUT_W); x SHALL be bits [STATE_W-RB-1 -: OUT_W] of (state ^ (state >> STATE_W/2)).
REQ-019 rot SHALL be state[STATE_W-1 -: RB], and perm SHALL be x rotated right by rot.
REQ-020 The cycle after an advance, noise SHALL register perm & mask of the new state, and noise_valid SHALL pulse high for exactly that one cycle (latency 1).
REQ-021 A mask change SHALL take effect only at the next sample.
REQ-022 Priority SHALL be seed_load > frame_start > advance, evaluated every cycle.
REQ-023 seed_load SHALL set state <= seed, latch seed into seed_reg, and set hold_cnt <= 0; no noise_valid pulse is generated.
REQ-024 frame_start SHALL set hold_cnt <= 0; any advance in the same cycle SHALL be suppressed.
REQ-025 A seed_load, frame_start or advance arriving simultaneously with reset SHALL be ignored.

Reset
REQ-026 Reset SHALL set state, seed_reg, hold_cnt and noise to 0, and noise_valid to 0.
REQ-027 Reset mid-sample SHALL discard any pending noise_valid.

Configuration
REQ-028 With PCG_NOISE_FRAME_RESEED_EN defined, frame_start SHALL also set state <= seed_reg, so every frame repeats identical noise.
REQ-029 Without PCG_NOISE_FRAME_RESEED_EN, frame_start SHALL only clear hold_cnt, and the state SHALL continue (animated noise).

Verification (STATE_W=16, OUT_W=8, default MULT/INC, mask=8'hFF)
REQ-030 Reset, then pix_en=1 constantly with HOLD=1 -> state 16'h1405 then 16'h219A; noise 8'hA0 then 8'h86, each with a one-cycle noise_valid.
REQ-031 HOLD=4, pix_en=1 -> state advances every 4th cycle; noise_valid has a 1-in-4 duty cycle.
REQ-032 HOLD=1, pix_en toggling 1,0,1 -> two advances only; noise is stable during the 0 cycle.
REQ-033 mask=8'h0F on the first sample -> noise=8'h00, since 8'hA0 & 8'h0F = 0.
REQ-034 seed_load seed=16'h0000 together with frame_start -> seed wins; hold_cnt=0; next advance gives 16'h1405.
REQ-035 With the macro: seed_load 16'h0000, run 3 samples, frame_start, run 3 samples -> identical sequences A0,86,... Without the macro -> the sequence continues.
